// File: rtl/eyearch_pkg.sv
// Shared types and field layout for the fetch/decode front end.
package eyearch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 16;

  // Instruction word field positions
  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned TYPE_MSB = 1;
  localparam int unsigned OPC_LSB  = 2;
  localparam int unsigned OPC_MSB  = 5;
  localparam int unsigned OPR_LSB  = 6;
  localparam int unsigned OPR_MSB  = 31;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    REG    = 2'b01,
    IMM    = 2'b10,
    BRANCH = 2'b11
  } inst_type_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small circular buffer holding fetched words; flush wins over push.
module fetch_fifo
  import eyearch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/count/storage values from push, pop and flush
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      assert (!(push && !flush && count_q == CNT_W'(DEPTH)));
      assert (!(pop && !flush && count_q == '0));
    end
  end

  // Storage array, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, redirect flush, field split.
module inst_fetch
  import eyearch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        inst_type,
  output logic [3:0]        inst_opcode,
  output logic [25:0]       inst_operands
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] word;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  inflight_next;
  logic [SUM_W-1:0]  occupancy;

  logic              req_fire;
  logic              out_fire;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            fifo_in;
  entry_t            fifo_head;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State, PC and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      assert (!(imem_resp_valid && inflight_q == '0));
      assert (!(fifo_push && fifo_full));
    end
  end

  // Next state: request/response bookkeeping and redirect handling
  always_comb begin
    req_fire      = imem_req_valid && imem_req_ready;
    out_fire      = out_valid && out_ready;
    inflight_next = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    inflight_d    = inflight_next;
    fifo_push     = 1'b0;
    fifo_pop      = out_fire;
    fifo_flush    = 1'b0;
    // Outside a flush every outstanding request is kept, so the oldest one
    // (the one answering now) was issued inflight_q words before pc_q.
    fifo_in.pc    = pc_q - ADDR_W'(inflight_q);
    fifo_in.word  = imem_resp_data;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = redirect_pc;
      drop_d     = inflight_next;
      state_d    = (inflight_next != '0) ? FLUSH : RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      if (imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          fifo_push = 1'b1;
        end
      end
      if (state_q == FLUSH && drop_d == '0) begin
        state_d = RUN;
      end
    end
  end

  // Outputs: request issue gated by credits, FIFO head split into fields
  always_comb begin
    occupancy      = SUM_W'(inflight_q) + SUM_W'(fifo_count);
    imem_req_valid = !rst && (state_q == RUN) && !redirect_valid &&
                     (occupancy < SUM_W'(DEPTH));
    imem_req_addr  = pc_q;
    out_valid      = !fifo_empty;
    out_pc         = '0;
    inst_type      = NONE;
    inst_opcode    = '0;
    inst_operands  = '0;
    if (!fifo_empty) begin
      out_pc        = fifo_head.pc;
      inst_type     = inst_type_t'(fifo_head.word[TYPE_MSB:TYPE_LSB]);
      inst_opcode   = fifo_head.word[OPC_MSB:OPC_LSB];
      inst_operands = fifo_head.word[OPR_MSB:OPR_LSB];
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then random traffic.
module tb_inst_fetch;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 2;
  localparam logic [15:0] RPC    = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [1:0]  inst_type;
  logic [3:0]  inst_opcode;
  logic [25:0] inst_operands;

  always #5 clk = ~clk;

  inst_fetch #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .inst_type       (inst_type),
    .inst_opcode     (inst_opcode),
    .inst_operands   (inst_operands)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  int          total = 0;
  int          bad   = 0;
  pend_t       pend[$];
  logic [15:0] fq[$];
  logic [15:0] req_log[$];
  logic [15:0] m_pc = RPC;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  bit          prev_rst = 1'b0;
  int          n_out = 0;
  int          n_drop = 0;
  logic [15:0] last_out_pc = '0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, a * 16'd7 + 16'd3};
  endfunction

  function automatic bit stale_any();
    foreach (pend[i]) if (pend[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the queue model, advance.
  task automatic step(input bit r, input bit rv, input logic [15:0] rp,
                      input bit ordy, input bit mrdy);
    bit          resp, exp_rv, rfire, ofire;
    logic [31:0] w;
    pend_t       p;
    int          due;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = ordy;
    imem_req_ready = mrdy;
    resp           = !r && pend.size() > 0 && pend[0].due <= cyc;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend[0].addr) : 32'($urandom);
    #1;
    if (!(r && !prev_rst)) begin
      exp_rv = !r && !rv && !stale_any() && (pend.size() + fq.size() < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", 32'(imem_req_addr), 32'(m_pc));
      chk("out_valid", 32'(out_valid), 32'(fq.size() > 0));
      w = (fq.size() > 0) ? mem_word(fq[0]) : 32'h0;
      chk("out_pc", 32'(out_pc), (fq.size() > 0) ? 32'(fq[0]) : 32'h0);
      chk("inst_type", 32'(inst_type), w % 4);
      chk("inst_opcode", 32'(inst_opcode), (w / 4) % 16);
      chk("inst_operands", 32'(inst_operands), w / 64);
    end
    rfire = imem_req_valid && mrdy;
    ofire = out_valid && ordy;
    if (rfire) req_log.push_back(imem_req_addr);
    if (ofire) begin
      n_out++;
      last_out_pc = out_pc;
    end
    @(posedge clk);
    if (r) begin
      pend.delete();
      fq.delete();
      req_log.delete();
      m_pc = RPC;
    end else if (rv) begin
      if (resp) begin
        void'(pend.pop_front());
        n_drop++;
      end
      foreach (pend[i]) pend[i].stale = 1'b1;
      fq.delete();
      m_pc = rp;
    end else begin
      if (ofire && fq.size() > 0) void'(fq.pop_front());
      if (resp) begin
        p = pend.pop_front();
        if (p.stale) n_drop++;
        else fq.push_back(p.addr);
      end
      if (rfire) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        pend.push_back('{imem_req_addr, due, 1'b0});
        last_due = due;
        m_pc = m_pc + 16'd1;
      end
    end
    prev_rst = r;
    cyc++;
    #1;
  endtask

  initial begin
    int n0, d0, i;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;

    // Reset, then streaming with 1-cycle memory; PC wraps from FFFF to 0
    step(1, 0, '0, 1, 1);
    step(1, 0, '0, 1, 1);
    lat = 1;
    for (int k = 0; k < 20; k++) step(0, 0, '0, 1, 1);
    chk("req_log_len", 32'(req_log.size() >= 2), 32'd1);
    if (req_log.size() >= 2) begin
      chk("first_req_addr", 32'(req_log[0]), 32'hFFFF);
      chk("wrap_req_addr", 32'(req_log[1]), 32'h0000);
    end

    // Decode stalled: buffer fills, requests stop, then drain in order
    for (int k = 0; k < 10; k++) step(0, 0, '0, 0, 1);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) step(0, 0, '0, 1, 1);

    // Latency 3, redirect to 0x0040 with two requests outstanding
    lat = 3;
    i = 0;
    while (!(pend.size() == 2 && !stale_any()) && i < 30) begin
      step(0, 0, '0, 1, 1);
      i++;
    end
    chk("two_inflight_reached", 32'(i < 30), 32'd1);
    d0 = n_drop; n0 = n_out;
    step(0, 1, 16'h0040, 1, 1);
    i = 0;
    while (n_out == n0 && i < 30) begin
      step(0, 0, '0, 1, 1);
      i++;
    end
    chk("redirect_first_out_seen", 32'(i < 30), 32'd1);
    chk("redirect_drops", 32'(n_drop - d0), 32'd2);
    chk("redirect_first_pc", 32'(last_out_pc), 32'h0040);

    // Redirect coinciding with an out handshake and a response
    lat = 1;
    i = 0;
    while (!(fq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc && !stale_any()) && i < 30) begin
      step(0, 0, '0, 1, 1);
      i++;
    end
    chk("coincide_reached", 32'(i < 30), 32'd1);
    d0 = n_drop; n0 = n_out;
    step(0, 1, 16'h1234, 1, 1);
    chk("coincide_handshake", 32'(n_out - n0), 32'd1);
    chk("coincide_resp_dropped", 32'(n_drop - d0), 32'd1);
    chk("coincide_fifo_empty", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) step(0, 0, '0, 1, 1);

    // Reset asserted while flushing one outstanding response
    lat = 3;
    i = 0;
    while (!(pend.size() == 1 && pend[0].due > cyc + 1 && !stale_any()) && i < 40) begin
      step(0, 0, '0, 1, 1);
      i++;
    end
    chk("flush1_reached", 32'(i < 40), 32'd1);
    step(0, 1, 16'h0100, 1, 1);
    chk("flush_blocks_req", 32'(imem_req_valid), 32'd0);
    step(1, 0, '0, 1, 1);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_fields", {inst_operands, inst_opcode, inst_type}, 32'd0);
    step(0, 0, '0, 1, 1);
    chk("post_rst_req_count", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) chk("post_rst_req_addr", 32'(req_log[0]), 32'hFFFF);

    // Random traffic against the queue model
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0 && pend.size() == 0) lat = $urandom_range(1, 4);
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 19) == 0),
           16'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
